// File: rtl/corevx_tlb_ctrl.sv
// rtl/corevx_tlb_ctrl.sv - TLB sequencing, victim selection, hit merge and invalidate sweep (option: COREVX_TLB_CTRL_MULTIHIT_CHECK_EN)
module corevx_tlb_ctrl #(
    parameter int ENTRIES_W = 4,
    parameter int WAYS_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_cmd,
    input  logic [19:0]                 req_vaddr,
    input  logic [7:0]                  req_accesstag,
    input  logic [21:0]                 req_phys,
    output logic                        resp_valid,
    output logic                        resp_hit,
    output logic [7:0]                  resp_accesstag,
    output logic [21:0]                 resp_phys,
    output logic                        flush_done,
    output logic                        err_multihit,
    output logic [2*(2**WAYS_W)-1:0]    way_command,
    output logic [19:0]                 way_vaddr,
    output logic [19:0]                 way_vaddr_w,
    output logic [7:0]                  way_accesstag_w,
    output logic [21:0]                 way_phys_w,
    output logic [ENTRIES_W-1:0]        way_invalidate_set_index,
    input  logic [(2**WAYS_W)-1:0]      way_hit,
    input  logic [8*(2**WAYS_W)-1:0]    way_accesstag_r,
    input  logic [22*(2**WAYS_W)-1:0]   way_phys_r
);
    localparam int WAYS    = 2**WAYS_W;
    localparam int ENTRIES = 2**ENTRIES_W;

    typedef enum logic {FLUSH = 1'b0, IDLE = 1'b1} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ENTRIES_W-1:0]   flush_idx;
    logic [WAYS_W-1:0]      victim;
    logic                   accept;
    logic                   last_idx;
    logic                   any_hit;
    logic [7:0]             hit_tag;
    logic [21:0]            hit_phys;

    assign accept   = req_valid && req_ready && (req_cmd != 2'd0);
    assign last_idx = (flush_idx == ENTRIES_W'(ENTRIES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FLUSH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FLUSH:   if (last_idx) next_state = IDLE;
            IDLE:    if (accept && req_cmd == 2'd3) next_state = FLUSH;
            default: next_state = FLUSH;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        way_command = '0;
        if (state == FLUSH) begin
            for (int i = 0; i < WAYS; i++) way_command[2*i +: 2] = 2'd3;
        end else if (accept) begin
            for (int i = 0; i < WAYS; i++) begin
                if (req_cmd == 2'd1) way_command[2*i +: 2] = 2'd1;
                else if (req_cmd == 2'd2 && victim == WAYS_W'(i)) way_command[2*i +: 2] = 2'd2;
            end
        end
    end

    // flush_idx wraps back to 0 on its own after the last index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_idx  <= '0;
            victim     <= '0;
            resp_valid <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            if (state == FLUSH)                    flush_idx <= flush_idx + 1'b1;
            else if (accept && req_cmd == 2'd3)    flush_idx <= '0;
            if (accept && req_cmd == 2'd2)         victim <= victim + 1'b1;
            resp_valid <= accept && (req_cmd == 2'd1);
            flush_done <= (state == FLUSH) && last_idx;
        end
    end

    assign way_vaddr                = req_vaddr;
    assign way_vaddr_w              = req_vaddr;
    assign way_accesstag_w          = req_accesstag;
    assign way_phys_w               = req_phys;
    assign way_invalidate_set_index = flush_idx;

    // Descending scan so the lowest-indexed hitting way wins
    always_comb begin
        hit_tag  = '0;
        hit_phys = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_tag  = way_accesstag_r[8*i +: 8];
                hit_phys = way_phys_r[22*i +: 22];
            end
        end
    end

    assign any_hit = |way_hit;

`ifdef COREVX_TLB_CTRL_MULTIHIT_CHECK_EN
    logic multi;
    assign multi          = (way_hit & (way_hit - 1'b1)) != '0;
    assign resp_hit       = any_hit && !multi;
    assign resp_accesstag = multi ? 8'd0 : hit_tag;
    assign resp_phys      = multi ? 22'd0 : hit_phys;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_multihit <= 1'b0;
        else if (resp_valid && multi) err_multihit <= 1'b1;
    end
`else
    assign resp_hit       = any_hit;
    assign resp_accesstag = hit_tag;
    assign resp_phys      = hit_phys;
    assign err_multihit   = 1'b0;
`endif

endmodule

// File: tb/tb_corevx_tlb_ctrl.sv
// tb/tb_corevx_tlb_ctrl.sv - directed bench for corevx_tlb_ctrl with a behavioural 4-way TLB model
module tb_corevx_tlb_ctrl;
    localparam int WAYS    = 4;
    localparam int ENTRIES = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [19:0] req_vaddr;
    logic [7:0]  req_accesstag;
    logic [21:0] req_phys;
    logic        resp_valid;
    logic        resp_hit;
    logic [7:0]  resp_accesstag;
    logic [21:0] resp_phys;
    logic        flush_done;
    logic        err_multihit;
    logic [7:0]  way_command;
    logic [19:0] way_vaddr;
    logic [19:0] way_vaddr_w;
    logic [7:0]  way_accesstag_w;
    logic [21:0] way_phys_w;
    logic [3:0]  way_invalidate_set_index;
    logic [3:0]  way_hit;
    logic [31:0] way_accesstag_r;
    logic [87:0] way_phys_r;

    bit          m_val [WAYS][ENTRIES];
    bit   [19:0] m_tag [WAYS][ENTRIES];
    bit   [7:0]  m_at_s[WAYS][ENTRIES];
    bit   [21:0] m_ph_s[WAYS][ENTRIES];
    bit   [3:0]  m_hit;
    bit   [7:0]  m_at[WAYS];
    bit   [21:0] m_ph[WAYS];

    logic        ovr_en;
    logic [3:0]  ovr_hit;
    logic [31:0] ovr_at;
    logic [87:0] ovr_ph;

    int n_checks = 0;
    int n_fail   = 0;

    corevx_tlb_ctrl #(.ENTRIES_W(4), .WAYS_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_vaddr(req_vaddr), .req_accesstag(req_accesstag), .req_phys(req_phys),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_accesstag(resp_accesstag),
        .resp_phys(resp_phys), .flush_done(flush_done), .err_multihit(err_multihit),
        .way_command(way_command), .way_vaddr(way_vaddr), .way_vaddr_w(way_vaddr_w),
        .way_accesstag_w(way_accesstag_w), .way_phys_w(way_phys_w),
        .way_invalidate_set_index(way_invalidate_set_index),
        .way_hit(way_hit), .way_accesstag_r(way_accesstag_r), .way_phys_r(way_phys_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Way model: registered resolve result, write/invalidate at the clock edge
    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            case (way_command[2*w +: 2])
                2'd1: begin
                    m_hit[w] <= m_val[w][way_vaddr[3:0]] && (m_tag[w][way_vaddr[3:0]] == way_vaddr);
                    m_at[w]  <= m_at_s[w][way_vaddr[3:0]];
                    m_ph[w]  <= m_ph_s[w][way_vaddr[3:0]];
                end
                2'd2: begin
                    m_val[w][way_vaddr_w[3:0]]  <= 1'b1;
                    m_tag[w][way_vaddr_w[3:0]]  <= way_vaddr_w;
                    m_at_s[w][way_vaddr_w[3:0]] <= way_accesstag_w;
                    m_ph_s[w][way_vaddr_w[3:0]] <= way_phys_w;
                    m_hit[w] <= 1'b0;
                end
                2'd3: begin
                    m_val[w][way_invalidate_set_index] <= 1'b0;
                    m_hit[w] <= 1'b0;
                end
                default: m_hit[w] <= 1'b0;
            endcase
        end
    end

    always_comb begin
        way_hit         = '0;
        way_accesstag_r = '0;
        way_phys_r      = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w]               = ovr_en ? ovr_hit[w] : m_hit[w];
            way_accesstag_r[8*w +: 8]  = ovr_en ? ovr_at[8*w +: 8] : m_at[w];
            way_phys_r[22*w +: 22]     = ovr_en ? ovr_ph[22*w +: 22] : m_ph[w];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic do_req(input logic [1:0] cmd, input logic [19:0] va, input logic [7:0] at,
                          input logic [21:0] ph, input logic [7:0] exp_cmd, input string tag);
        req_valid     = 1'b1;
        req_cmd       = cmd;
        req_vaddr     = va;
        req_accesstag = at;
        req_phys      = ph;
        #1;
        check(tag, {24'd0, way_command}, {24'd0, exp_cmd});
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd   = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_cmd = 2'd0; req_vaddr = '0;
        req_accesstag = '0; req_phys = '0;
        ovr_en = 1'b0; ovr_hit = '0; ovr_at = '0; ovr_ph = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_err", err_multihit, 0);
        check("rst_way_cmd", way_command, 8'hFF);

        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b1; req_cmd = 2'd1; req_vaddr = 20'h00000;
        for (int i = 0; i < ENTRIES; i++) begin
            check("sweep_ready", req_ready, 0);
            check("sweep_idx", way_invalidate_set_index, i);
            check("sweep_cmd", way_command, 8'hFF);
            check("sweep_no_done", flush_done, 0);
            @(negedge clk);
        end
        check("sweep_end_ready", req_ready, 1);
        check("sweep_done_pulse", flush_done, 1);
        check("first_accept_cmd", way_command, 8'h55);
        @(negedge clk);
        req_valid = 1'b0; req_cmd = 2'd0;
        check("done_single_pulse", flush_done, 0);
        check("first_resp_valid", resp_valid, 1);
        check("first_resp_miss", resp_hit, 0);
        @(negedge clk);
        check("resp_valid_drop", resp_valid, 0);

        do_req(2'd2, 20'h00010, 8'h01, 22'h1, 8'h02, "wr0_way0");
        do_req(2'd2, 20'h00020, 8'h02, 22'h2, 8'h08, "wr1_way1");
        do_req(2'd2, 20'h00030, 8'h03, 22'h3, 8'h20, "wr2_way2");
        do_req(2'd2, 20'h00040, 8'h04, 22'h4, 8'h80, "wr3_way3");
        do_req(2'd2, 20'h00050, 8'h05, 22'h5, 8'h02, "wr4_wrap_way0");

        do_req(2'd2, 20'h12345, 8'h0F, 22'h2ABCD, 8'h08, "wr5_way1");
        do_req(2'd1, 20'h12345, 8'h00, 22'h0, 8'h55, "res_cmd");
        check("hit_valid", resp_valid, 1);
        check("hit_hit", resp_hit, 1);
        check("hit_phys", resp_phys, 22'h2ABCD);
        check("hit_tag", resp_accesstag, 8'h0F);
        do_req(2'd1, 20'h12355, 8'h00, 22'h0, 8'h55, "res2_cmd");
        check("miss_valid_b2b", resp_valid, 1);
        check("miss_hit", resp_hit, 0);
        check("miss_phys", resp_phys, 0);
        check("miss_tag", resp_accesstag, 0);

        do_req(2'd3, 20'h12345, 8'h00, 22'h0, 8'h00, "flush_accept_cmd");
        for (int i = 0; i < ENTRIES; i++) begin
            check("fl_ready", req_ready, 0);
            check("fl_idx", way_invalidate_set_index, i);
            @(negedge clk);
        end
        check("fl_done", flush_done, 1);
        check("fl_ready_back", req_ready, 1);
        do_req(2'd1, 20'h12345, 8'h00, 22'h0, 8'h55, "post_flush_res");
        check("post_flush_valid", resp_valid, 1);
        check("post_flush_miss", resp_hit, 0);

        ovr_en = 1'b1; ovr_hit = 4'b0110;
        ovr_at = {8'h44, 8'h33, 8'h22, 8'h11};
        ovr_ph = {22'h04444, 22'h03333, 22'h3AAAA, 22'h01111};
        do_req(2'd1, 20'h00000, 8'h00, 22'h0, 8'h55, "mh_res");
`ifdef COREVX_TLB_CTRL_MULTIHIT_CHECK_EN
        check("mh_hit", resp_hit, 0);
        check("mh_tag", resp_accesstag, 0);
        check("mh_phys", resp_phys, 0);
        @(negedge clk);
        check("mh_err", err_multihit, 1);
        ovr_en = 1'b0;
        do_req(2'd1, 20'h00000, 8'h00, 22'h0, 8'h55, "mh_res2");
        @(negedge clk);
        check("mh_err_sticky", err_multihit, 1);
`else
        check("mh_hit", resp_hit, 1);
        check("mh_tag", resp_accesstag, 8'h22);
        check("mh_phys", resp_phys, 22'h3AAAA);
        @(negedge clk);
        check("mh_err", err_multihit, 0);
        ovr_en = 1'b0;
`endif

        do_req(2'd3, 20'h00000, 8'h00, 22'h0, 8'h00, "flush2_cmd");
        repeat (7) @(negedge clk);
        check("mid_idx7", way_invalidate_set_index, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", req_ready, 0);
        check("async_idx", way_invalidate_set_index, 0);
        check("async_resp_valid", resp_valid, 0);
        check("async_done", flush_done, 0);
        check("async_err", err_multihit, 0);
        check("async_cmd", way_command, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        check("restart_idx0", way_invalidate_set_index, 0);
        @(negedge clk);
        check("restart_idx1", way_invalidate_set_index, 1);
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
        check("restart_ready", req_ready, 1);
        do_req(2'd2, 20'h00001, 8'h00, 22'h0, 8'h02, "victim_reset_way0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
